ov7670_sccb_config: RTL and testbench
=====================================

# ov7670_sccb_config

Camera configuration sequencer for the OV7670 front end. On a start pulse it walks a fixed register table and issues SCCB 3-phase write transactions (ID 0x42, register, value) that put the sensor into RGB565 output, inserting a settle delay after the soft reset entry. It also shares the SCCB bus with an optional host write port. It sits beside the pixel capture block and must report `done` before captured frames are trusted.

## Interface
Parameters:
- `QUARTER_CYC`, default 63: clk cycles per SCCB quarter-bit; 25 MHz gives about 100 kHz SIOC. Legal range is 1 and up.
- `DELAY_CYC`, default 250000: clk cycles of wait after a delay entry, 10 ms at 25 MHz. Legal range is 1 and up.

Ports:
- `clk` in 1: single clock for all logic.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle pulse that begins the table sequence.
- `host_req` in 1: host write request. Held high until `host_ack`.
- `host_addr` in 8: host register address.
- `host_data` in 8: host register value.
- `host_ack` out 1: one-cycle pulse when the host transaction completes.
- `sioc` out 1: SCCB clock, push-pull.
- `siod_oe` out 1: 1 pulls SIOD low; 0 releases it (pulled high externally).
- `busy` out 1: a table sequence or host transaction is in progress.
- `done` out 1: sticky; the table sequence has completed.

## Operation
- Table entries are 16 bits wide, `{addr, data}`, with index 0 first:
  - 0x1280
  - DELAY
  - 0x1204
  - 0x40D0
  - 0x1101
  - 0x0C00
  - 0x3E00
  - END
- DELAY and END are distinct internal markers, not bus values.
- States are IDLE, LOAD, START, BITS, STOP, GAP, DELAY, DONE.
- IDLE or DONE, on `start`:
  - clear `done`, set `busy`, set index to 0, go to LOAD.
- LOAD:
  - data entry: latch the 24-bit frame `{0x42, addr, data}` and go to START.
  - DELAY entry: go to DELAY.
  - END entry: go to DONE.
- START: 2 quarters.
  - q0: `sioc`=1, `siod_oe`=0.
  - q1: `sioc`=1, `siod_oe`=1.
- BITS: 27 bits, 4 quarters each.
  - q0 and q1: `sioc`=0.
  - q2 and q3: `sioc`=1.
  - `siod_oe` changes only at q0.
  - For each byte, 8 data bits go out MSB first with `siod_oe` = ~bit, then a 9th don't-care bit with `siod_oe`=0.
  - The ACK bit is not sampled.
- STOP: 3 quarters.
  - q0: `sioc`=0, `siod_oe`=1.
  - q1: `sioc`=1, `siod_oe`=1.
  - q2: `sioc`=1, `siod_oe`=0.
- GAP: 4 quarters with the bus idle (`sioc`=1, `siod_oe`=0).
  - Table transaction: increment the index, then go to LOAD.
  - Host transaction: pulse `host_ack`, then return to the state it was launched from (IDLE or DONE).
- DELAY: count `DELAY_CYC` cycles with the bus idle, increment the index, go to LOAD.
- DONE: `done`=1, `busy`=0.
- Arbitration:
  - A host write launches only from IDLE or DONE, with frame `{0x42, host_addr, host_data}`.
  - `busy`=1 for the duration of a host write.
  - A `host_req` that arrives during the table sequence waits and is served immediately after DONE is entered.
  - `start` and `host_req` in the same IDLE or DONE cycle: `start` wins; the host waits.
  - `start` while `busy` is ignored.
- Reset values: `sioc`=1, `siod_oe`=0, `busy`=0, `done`=0, `host_ack`=0; state IDLE, index 0.
- Reset mid-transaction abandons the bus. The next cycle shows idle levels, and no STOP is generated.

## Timing
- A quarter lasts exactly `QUARTER_CYC` clk cycles. The quarter counter reloads on every state entry.
- One write transaction spans 2+108+3+4 = 117 quarters, START entry through GAP exit.
- LOAD takes 1 cycle.
- `busy` rises the cycle after `start` is sampled.
- `done` rises, and `busy` falls, 1 cycle after LOAD sees END.
- `host_ack` is asserted during the last GAP cycle. The host may drop `host_req` the cycle after.
- `host_addr` and `host_data` are latched at launch; changes after launch are ignored.
- Outputs are registered, with no combinational path from inputs to outputs.

## Configuration
- `OV7670_CFG_HOST_WR_EN` defined: the host write port and arbitration behave as described above.
- Not defined:
  - `host_req`, `host_addr` and `host_data` are ignored.
  - `host_ack` is tied to 0.
  - No host transactions ever launch, and the table sequence is unchanged.

## Test plan
All scenarios use `QUARTER_CYC`=2 and `DELAY_CYC`=20; one transaction is 234 cycles.
- Start after reset -> bench decodes SIOD on SIOC rising edges:
  - first frame is bytes 0x42, 0x12, 0x80;
  - no bus activity for 20 cycles (DELAY);
  - then frames 0x42/0x12/0x04, 0x42/0x40/0xD0, 0x42/0x11/0x01, 0x42/0x0C/0x00, 0x42/0x3E/0x00;
  - `done`=1 and `busy`=0 afterwards.
- Reset values: `sioc`=1, `siod_oe`=0, `busy`=0, `done`=0, `host_ack`=0 during and after reset. SIOD falls during SIOC high only at START, and rises during SIOC high only at STOP.
- With the macro on, in DONE, `host_req` with 0x6B/0x4A -> frame 0x42/0x6B/0x4A, a single `host_ack` pulse 234 cycles after launch, and `done` stays 1.
- `host_req` raised during table frame 3 -> the host frame appears only after the END entry. Also `start`+`host_req` in the same cycle -> table first.
- `reset` asserted mid-BITS -> next cycle `sioc`=1 and `siod_oe`=0; a later `start` replays the table from 0x1280.
- Macro off, `host_req` held for 1000 cycles in IDLE -> no bus activity and `host_ack` never 1.

Source files
------------

// File: rtl/ov7670_sccb_config.sv
// OV7670 SCCB configuration sequencer.
// Walks a fixed register table (RGB565 setup) issuing 3-phase SCCB writes
// with a settle delay after soft reset, and shares the bus with an optional
// host write port enabled by the OV7670_CFG_HOST_WR_EN macro.
module ov7670_sccb_config #(
    parameter int QUARTER_CYC = 63,
    parameter int DELAY_CYC   = 250000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       host_req,
    input  logic [7:0] host_addr,
    input  logic [7:0] host_data,
    output logic       host_ack,
    output logic       sioc,
    output logic       siod_oe,
    output logic       busy,
    output logic       done
);
    localparam int QW = (QUARTER_CYC > 1) ? $clog2(QUARTER_CYC) : 1;
    localparam int DW = (DELAY_CYC > 1) ? $clog2(DELAY_CYC) : 1;
    localparam logic [QW-1:0] Q_LAST = QW'(QUARTER_CYC - 1);
    localparam logic [DW-1:0] D_LAST = DW'(DELAY_CYC - 1);
    localparam logic [1:0] K_DATA = 2'd0, K_DELAY = 2'd1, K_END = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_START, S_BITS, S_STOP, S_GAP, S_DELAY, S_DONE
    } state_t;

    // {kind, addr, data}; DELAY and END are markers, never driven on the bus
    function automatic logic [17:0] tbl(input logic [2:0] i);
        case (i)
            3'd0:    tbl = {K_DATA, 16'h1280};
            3'd1:    tbl = {K_DELAY, 16'h0000};
            3'd2:    tbl = {K_DATA, 16'h1204};
            3'd3:    tbl = {K_DATA, 16'h40D0};
            3'd4:    tbl = {K_DATA, 16'h1101};
            3'd5:    tbl = {K_DATA, 16'h0C00};
            3'd6:    tbl = {K_DATA, 16'h3E00};
            default: tbl = {K_END, 16'h0000};
        endcase
    endfunction

    state_t          state_q, state_d;
    logic [2:0]      idx_q, idx_d;
    logic [23:0]     frame_q, frame_d;
    logic [QW-1:0]   qcnt_q, qcnt_d;
    logic [1:0]      quarter_q, quarter_d;
    logic [4:0]      bit_q, bit_d;
    logic [3:0]      pos_q, pos_d;
    logic [DW-1:0]   dcnt_q, dcnt_d;
    logic            host_q, host_d;
    logic            ret_done_q, ret_done_d;
    logic            hold_q, hold_d;
    logic            sioc_q, sioc_d;
    logic            siod_oe_q, siod_oe_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            host_ack_q, host_ack_d;
    logic [17:0]     ent;
    logic            q_last;
    logic            host_go;

    // hold_q masks the cycle right after host_ack, when host_req may still be high
`ifdef OV7670_CFG_HOST_WR_EN
    assign host_go = host_req & ~hold_q;
`else
    logic unused_host;
    assign unused_host = host_req ^ hold_q;
    assign host_go     = 1'b0;
`endif

    // Next-state, counters and registered bus levels derived from the next state
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        frame_d    = frame_q;
        qcnt_d     = qcnt_q;
        quarter_d  = quarter_q;
        bit_d      = bit_q;
        pos_d      = pos_q;
        dcnt_d     = dcnt_q;
        host_d     = host_q;
        ret_done_d = ret_done_q;
        hold_d     = 1'b0;
        busy_d     = busy_q;
        done_d     = done_q;
        ent        = tbl(idx_q);
        q_last     = (qcnt_q == Q_LAST);

        if (q_last) begin
            qcnt_d    = '0;
            quarter_d = quarter_q + 2'd1;
        end else begin
            qcnt_d = qcnt_q + QW'(1);
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                qcnt_d    = '0;
                quarter_d = '0;
                if (start) begin
                    done_d  = 1'b0;
                    busy_d  = 1'b1;
                    idx_d   = '0;
                    host_d  = 1'b0;
                    state_d = S_LOAD;
                end else if (host_go) begin
                    frame_d    = {8'h42, host_addr, host_data};
                    host_d     = 1'b1;
                    ret_done_d = (state_q == S_DONE);
                    busy_d     = 1'b1;
                    state_d    = S_START;
                end
            end
            S_LOAD: begin
                qcnt_d    = '0;
                quarter_d = '0;
                dcnt_d    = '0;
                case (ent[17:16])
                    K_DATA: begin
                        frame_d = {8'h42, ent[15:0]};
                        state_d = S_START;
                    end
                    K_DELAY: state_d = S_DELAY;
                    default: begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_DONE;
                    end
                endcase
            end
            S_START: begin
                if (q_last && quarter_q == 2'd1) begin
                    quarter_d = '0;
                    bit_d     = '0;
                    pos_d     = '0;
                    state_d   = S_BITS;
                end
            end
            S_BITS: begin
                if (q_last && quarter_q == 2'd3) begin
                    if (bit_q == 5'd26) begin
                        quarter_d = '0;
                        state_d   = S_STOP;
                    end else begin
                        bit_d = bit_q + 5'd1;
                        if (pos_q == 4'd8) begin
                            pos_d = '0;
                        end else begin
                            pos_d   = pos_q + 4'd1;
                            frame_d = {frame_q[22:0], 1'b0};
                        end
                    end
                end
            end
            S_STOP: begin
                if (q_last && quarter_q == 2'd2) begin
                    quarter_d = '0;
                    state_d   = S_GAP;
                end
            end
            S_GAP: begin
                if (q_last && quarter_q == 2'd3) begin
                    if (host_q) begin
                        host_d  = 1'b0;
                        hold_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ret_done_q ? S_DONE : S_IDLE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = S_LOAD;
                    end
                end
            end
            S_DELAY: begin
                qcnt_d    = '0;
                quarter_d = '0;
                if (dcnt_q == D_LAST) begin
                    idx_d   = idx_q + 3'd1;
                    state_d = S_LOAD;
                end else begin
                    dcnt_d = dcnt_q + DW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        sioc_d    = 1'b1;
        siod_oe_d = 1'b0;
        case (state_d)
            S_START: siod_oe_d = (quarter_d == 2'd1);
            S_BITS: begin
                sioc_d    = quarter_d[1];
                siod_oe_d = (pos_d == 4'd8) ? 1'b0 : ~frame_d[23];
            end
            S_STOP: begin
                sioc_d    = (quarter_d != 2'd0);
                siod_oe_d = (quarter_d != 2'd2);
            end
            default: ;
        endcase
        host_ack_d = host_d && (state_d == S_GAP) && (quarter_d == 2'd3) && (qcnt_d == Q_LAST);
    end

    // State and output registers; reset drops the bus to idle without a STOP
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            frame_q    <= '0;
            qcnt_q     <= '0;
            quarter_q  <= '0;
            bit_q      <= '0;
            pos_q      <= '0;
            dcnt_q     <= '0;
            host_q     <= 1'b0;
            ret_done_q <= 1'b0;
            hold_q     <= 1'b0;
            sioc_q     <= 1'b1;
            siod_oe_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            host_ack_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            frame_q    <= frame_d;
            qcnt_q     <= qcnt_d;
            quarter_q  <= quarter_d;
            bit_q      <= bit_d;
            pos_q      <= pos_d;
            dcnt_q     <= dcnt_d;
            host_q     <= host_d;
            ret_done_q <= ret_done_d;
            hold_q     <= hold_d;
            sioc_q     <= sioc_d;
            siod_oe_q  <= siod_oe_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            host_ack_q <= host_ack_d;
        end
    end

    assign sioc     = sioc_q;
    assign siod_oe  = siod_oe_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign host_ack = host_ack_q;
endmodule

// File: tb/tb_ov7670_sccb_config.sv
// Bench for ov7670_sccb_config: decodes SIOC/SIOD into frames and checks them
// against a table-level model; host scenarios follow OV7670_CFG_HOST_WR_EN.
module tb_ov7670_sccb_config;
    logic clk = 1'b0, reset = 1'b1, start = 1'b0, host_req = 1'b0;
    logic [7:0] host_addr = 8'h00, host_data = 8'h00;
    logic host_ack, sioc, siod_oe, busy, done;
    int cyc = 0;
    int n_cmp = 0, n_fail = 0;

    ov7670_sccb_config #(.QUARTER_CYC(2), .DELAY_CYC(20)) dut (
        .clk(clk), .reset(reset), .start(start), .host_req(host_req),
        .host_addr(host_addr), .host_data(host_data), .host_ack(host_ack),
        .sioc(sioc), .siod_oe(siod_oe), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // bus decoder
    logic [23:0] got[$];
    int start_q[$], stop_q[$];
    logic [27:0] fr;
    int nb = 0, rise_cnt = 0, bad_cond = 0, bad_ack = 0, ack_cnt = 0, done_low = 0, busy_cnt = 0;
    logic in_frame = 1'b0, p_sioc = 1'b1, p_oe = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            in_frame = 1'b0;
        end else begin
            if (sioc && p_sioc && !p_oe && siod_oe) begin
                if (in_frame) bad_cond++;
                in_frame = 1'b1; nb = 0; fr = '0;
                start_q.push_back(cyc);
            end else if (sioc && p_sioc && p_oe && !siod_oe) begin
                if (!in_frame || nb != 28) bad_cond++;
                else begin
                    got.push_back({fr[27:20], fr[18:11], fr[9:2]});
                    if (!(fr[19] && fr[10] && fr[1])) bad_ack++;
                end
                in_frame = 1'b0;
                stop_q.push_back(cyc);
            end
            if (sioc && !p_sioc) begin
                rise_cnt++;
                if (in_frame) begin fr = {fr[26:0], ~siod_oe}; nb++; end
                else bad_cond++;
            end
            if (host_ack) ack_cnt++;
            if (!done) done_low++;
            if (busy) busy_cnt++;
        end
        p_sioc = sioc;
        p_oe   = siod_oe;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // reference: table-level model of the frames a full sequence emits
    logic [23:0] exp_q[$];
    task automatic build_model();
        int t[8] = '{32'h1280, -1, 32'h1204, 32'h40D0, 32'h1101, 32'h0C00, 32'h3E00, -2};
        logic [15:0] e;
        for (int i = 0; i < 8; i++) begin
            if (t[i] == -2) break;
            if (t[i] == -1) continue;
            e = t[i][15:0];
            exp_q.push_back({8'h42, e});
        end
    endtask

    task automatic check_frames(input string tag, input int extra);
        chk({tag, "_nframes"}, got.size(), exp_q.size() + extra);
        for (int i = 0; i < exp_q.size(); i++)
            if (i < got.size()) chk({tag, "_frame"}, got[i], exp_q[i]);
        chk({tag, "_cond"}, bad_cond, 0);
        chk({tag, "_ackbits"}, bad_ack, 0);
    endtask

    task automatic clear_mon();
        got.delete(); start_q.delete(); stop_q.delete();
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (!(done === 1'b1 && busy === 1'b0) && n < budget) begin @(negedge clk); n++; end
        chk({tag, "_done_to"}, n < budget, 1);
    endtask

    task automatic wait_ack(input string tag, input int budget, output int at);
        int n = 0;
        @(negedge clk);
        while (host_ack !== 1'b1 && n < budget) begin @(negedge clk); n++; end
        chk({tag, "_ack_to"}, n < budget, 1);
        at = cyc;
    endtask

    initial begin
        int launch, at, a0;
        logic [7:0] ha, hd;
        build_model();

        // reset values
        repeat (3) begin
            @(negedge clk);
            chk("rst_vals", {sioc, siod_oe, busy, done, host_ack}, 5'b10000);
        end
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("post_rst_vals", {sioc, siod_oe, busy, done, host_ack}, 5'b10000);
        repeat ($urandom_range(0, 15)) @(posedge clk);

        // full table run, with an ignored start while busy
        clear_mon();
        bad_cond = 0;
        @(posedge clk); #1 start = 1'b1;
        @(negedge clk); chk("busy_pre", busy, 0);
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk); chk("busy_rise", busy, 1); chk("done_clr", done, 0);
        at = 0;
        while (got.size() < 3 && at < 2000) begin @(negedge clk); at++; end
        pulse_start();
        wait_done("runA", 3000);
        repeat (50) @(negedge clk);
        check_frames("runA", 0);
        chk("runA_nstart", start_q.size(), 6);
        if (start_q.size() >= 3 && stop_q.size() >= 2) begin
            chk("delay_gap", start_q[1] - stop_q[0], 34);
            chk("normal_gap", start_q[2] - stop_q[1], 13);
        end
        chk("runA_end", {busy, done}, 2'b01);

`ifdef OV7670_CFG_HOST_WR_EN
        // host write from DONE, address/data changed after launch
        clear_mon(); done_low = 0; a0 = ack_cnt;
        @(posedge clk); #1 host_req = 1'b1; host_addr = 8'h6B; host_data = 8'h4A;
        @(negedge clk); launch = cyc;
        repeat (10) @(posedge clk);
        #1 host_addr = 8'($urandom); host_data = 8'($urandom);
        @(negedge clk); chk("host_busy", busy, 1);
        wait_ack("host1", 400, at);
        @(posedge clk); #1 host_req = 1'b0;
        chk("host_ack_lat", at - launch, 234);
        repeat (300) @(negedge clk);
        chk("host1_nack", ack_cnt - a0, 1);
        chk("host1_nframes", got.size(), 1);
        if (got.size() >= 1) chk("host1_frame", got[0], 24'h426B4A);
        chk("host1_done_kept", done_low, 0);
        chk("host1_end", {busy, done}, 2'b01);

        // start and host_req in the same cycle: table first
        clear_mon(); a0 = ack_cnt;
        ha = 8'($urandom); hd = 8'($urandom);
        @(posedge clk); #1 start = 1'b1; host_req = 1'b1; host_addr = ha; host_data = hd;
        @(posedge clk); #1 start = 1'b0;
        wait_ack("host2", 3000, at);
        chk("host2_done_at_ack", done, 1);
        @(posedge clk); #1 host_req = 1'b0;
        repeat (20) @(negedge clk);
        check_frames("host2", 1);
        if (got.size() >= 7) chk("host2_frame", got[6], {8'h42, ha, hd});
        chk("host2_nack", ack_cnt - a0, 1);

        // host_req raised during table frame 3
        clear_mon(); a0 = ack_cnt;
        ha = 8'($urandom); hd = 8'($urandom);
        pulse_start();
        at = 0;
        while (start_q.size() < 3 && at < 2000) begin @(negedge clk); at++; end
        @(posedge clk); #1 host_req = 1'b1; host_addr = ha; host_data = hd;
        wait_ack("host3", 3000, at);
        chk("host3_done_at_ack", done, 1);
        @(posedge clk); #1 host_req = 1'b0;
        repeat (20) @(negedge clk);
        check_frames("host3", 1);
        if (got.size() >= 7) chk("host3_frame", got[6], {8'h42, ha, hd});
        chk("host3_nack", ack_cnt - a0, 1);
`endif

        // reset in the middle of BITS, then replay
        pulse_start();
        repeat ($urandom_range(10, 200)) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("midrst_vals", {sioc, siod_oe, busy, done, host_ack}, 5'b10000);
        @(posedge clk); #1 reset = 1'b0;
        clear_mon(); bad_cond = 0; bad_ack = 0;
        pulse_start();
        @(negedge clk); chk("replay_busy", busy, 1);
        wait_done("replay", 3000);
        repeat (20) @(negedge clk);
        check_frames("replay", 0);

`ifndef OV7670_CFG_HOST_WR_EN
        // host port disabled: requests in IDLE do nothing
        @(posedge clk); #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        clear_mon(); a0 = ack_cnt; at = rise_cnt; busy_cnt = 0;
        host_req = 1'b1; host_addr = 8'($urandom); host_data = 8'($urandom);
        repeat (1000) @(negedge clk);
        chk("off_rises", rise_cnt - at, 0);
        chk("off_nack", ack_cnt - a0, 0);
        chk("off_busy", busy_cnt, 0);
        chk("off_nframes", got.size(), 0);
        pulse_start();
        wait_done("off_run", 3000);
        repeat (300) @(negedge clk);
        check_frames("off_run", 0);
        chk("off_run_nack", ack_cnt - a0, 0);
        host_req = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
